// File: rtl/rv_test_monitor_pkg.sv
// Shared constants for the end-of-test monitor: instruction encodings, FSM
// states, default watchdog length and the bench-visible result strings.
package rv_test_monitor_pkg;

   localparam logic [31:0] INSTR_ECALL     = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK    = 32'h0010_0073;
   localparam int          DEFAULT_TIMEOUT = 50000;

   localparam ASSERT_SUCCESS = "ASSERT_SUCCESS";
   localparam ASSERT_FAIL    = "ASSERT_FAIL";

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } mon_state_e;

   function automatic logic is_terminal(input mon_state_e s);
      return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
   endfunction

endpackage

// File: rtl/rv_test_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   cnt <= '0;
      else if (clr)                 cnt <= '0;
      else if (en && (cnt != '1))   cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/rv_test_monitor.sv
// End-of-test monitor: decodes ECALL/EBREAK off the fetch bus, runs a watchdog
// and exposes sticky pass/fail/timeout status with captured diagnostics.
module rv_test_monitor
   import rv_test_monitor_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   parameter int CNT_W          = 32,
   parameter int XLEN           = 32
) (
   input  logic             sysClk,
   input  logic             sysRes,
   input  logic             clear,
   input  logic             instrValid,
   input  logic [XLEN-1:0]  instrData,
   input  logic [XLEN-1:0]  instrPc,
   input  logic [XLEN-1:0]  gpValue,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic             doneStrobe,
   output logic             cpuHalt,
   output logic [XLEN-1:0]  endPc,
   output logic [XLEN-1:0]  failTestNum,
   output logic [CNT_W-1:0] cycleCount,
   output logic [CNT_W-1:0] fetchCount
);

   mon_state_e state;
   logic       run, hit_ecall, hit_ebreak, wd_hit;
   logic [63:0] cyc_ext;

   assign run        = (state == ST_RUN);
   assign hit_ecall  = instrValid && (instrData[31:0] == INSTR_ECALL);
   assign hit_ebreak = instrValid && (instrData[31:0] == INSTR_EBREAK);
   // Widen before comparing so a narrow counter can never alias the limit.
   assign cyc_ext    = 64'(cycleCount);
   assign wd_hit     = (cyc_ext == 64'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge sysClk or negedge sysRes) begin
      if (!sysRes) begin
         state       <= ST_IDLE;
         endPc       <= '0;
         failTestNum <= '0;
         doneStrobe  <= 1'b0;
      end else if (clear) begin
         state       <= ST_RUN;
         endPc       <= '0;
         failTestNum <= '0;
         doneStrobe  <= 1'b0;
      end else begin
         doneStrobe <= 1'b0;
         case (state)
            ST_IDLE: state <= ST_RUN;
            ST_RUN: begin
               if (hit_ecall) begin
                  state      <= ST_PASS;
                  endPc      <= instrPc;
                  doneStrobe <= 1'b1;
               end else if (hit_ebreak) begin
                  state       <= ST_FAIL;
                  endPc       <= instrPc;
                  failTestNum <= gpValue;
                  doneStrobe  <= 1'b1;
               end else if (wd_hit) begin
                  state      <= ST_TIMEOUT;
                  doneStrobe <= 1'b1;
               end
            end
            default: state <= state;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk(sysClk), .rst_n(sysRes), .clr(clear), .en(run), .cnt(cycleCount)
   );

   sat_counter #(.W(CNT_W)) u_fetch_cnt (
      .clk(sysClk), .rst_n(sysRes), .clr(clear), .en(run && instrValid), .cnt(fetchCount)
   );

   assign done    = is_terminal(state);
   assign pass    = (state == ST_PASS);
   assign fail    = (state == ST_FAIL);
   assign timeout = (state == ST_TIMEOUT);
   assign cpuHalt = done;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Randomized bench for rv_test_monitor: two instances (short watchdog, narrow
// counters) share stimulus and are compared every cycle to an outcome model.
module tb_rv_test_monitor;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        sysClk, sysRes, clear, instrValid;
   logic [31:0] instrData, instrPc, gpValue;

   logic        done0, pass0, fail0, to0, strb0, halt0;
   logic [31:0] ep0, ftn0, cc0, fc0;
   logic        done1, pass1, fail1, to1, strb1, halt1;
   logic [31:0] ep1, ftn1;
   logic [3:0]  cc1, fc1;

   rv_test_monitor #(.TIMEOUT_CYCLES(20), .CNT_W(32), .XLEN(32)) dut0 (
      .sysClk(sysClk), .sysRes(sysRes), .clear(clear), .instrValid(instrValid),
      .instrData(instrData), .instrPc(instrPc), .gpValue(gpValue),
      .done(done0), .pass(pass0), .fail(fail0), .timeout(to0), .doneStrobe(strb0),
      .cpuHalt(halt0), .endPc(ep0), .failTestNum(ftn0), .cycleCount(cc0), .fetchCount(fc0)
   );

   rv_test_monitor #(.TIMEOUT_CYCLES(100), .CNT_W(4), .XLEN(32)) dut1 (
      .sysClk(sysClk), .sysRes(sysRes), .clear(clear), .instrValid(instrValid),
      .instrData(instrData), .instrPc(instrPc), .gpValue(gpValue),
      .done(done1), .pass(pass1), .fail(fail1), .timeout(to1), .doneStrobe(strb1),
      .cpuHalt(halt1), .endPc(ep1), .failTestNum(ftn1), .cycleCount(cc1), .fetchCount(fc1)
   );

   initial sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // Outcome model: 0 running, 1 passed, 2 failed, 3 timed out.
   longint lim[2]  = '{20, 100};
   longint maxv[2] = '{64'hFFFF_FFFF, 15};
   bit     started[2];
   int     outcome[2];
   bit     m_strb[2];
   longint m_cyc[2], m_fch[2];
   logic [31:0] m_ep[2], m_gp[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         started[k] = 0; outcome[k] = 0; m_strb[k] = 0;
         m_cyc[k] = 0; m_fch[k] = 0; m_ep[k] = '0; m_gp[k] = '0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (clear) begin
            started[k] = 1; outcome[k] = 0; m_strb[k] = 0;
            m_cyc[k] = 0; m_fch[k] = 0; m_ep[k] = '0; m_gp[k] = '0;
         end else if (!started[k]) begin
            started[k] = 1; m_strb[k] = 0;
         end else if (outcome[k] != 0) begin
            m_strb[k] = 0;
         end else begin
            if (instrValid && instrData == ECALL) begin
               outcome[k] = 1; m_ep[k] = instrPc;
            end else if (instrValid && instrData == EBREAK) begin
               outcome[k] = 2; m_ep[k] = instrPc; m_gp[k] = gpValue;
            end else if (m_cyc[k] == lim[k] - 1) begin
               outcome[k] = 3;
            end
            m_strb[k] = (outcome[k] != 0);
            if (m_cyc[k] < maxv[k]) m_cyc[k]++;
            if (instrValid && m_fch[k] < maxv[k]) m_fch[k]++;
         end
      end
   endtask

   task automatic check_dut(input int k, input logic dn, ps, fl, tmo, st, ht,
                            input logic [31:0] ep, ft, input logic [63:0] cc, fc);
      chk($sformatf("d%0d.done", k),    64'(dn),  64'(outcome[k] != 0));
      chk($sformatf("d%0d.pass", k),    64'(ps),  64'(outcome[k] == 1));
      chk($sformatf("d%0d.fail", k),    64'(fl),  64'(outcome[k] == 2));
      chk($sformatf("d%0d.timeout", k), 64'(tmo), 64'(outcome[k] == 3));
      chk($sformatf("d%0d.strobe", k),  64'(st),  64'(m_strb[k]));
      chk($sformatf("d%0d.halt", k),    64'(ht),  64'(outcome[k] != 0));
      chk($sformatf("d%0d.endPc", k),   64'(ep),  64'(m_ep[k]));
      chk($sformatf("d%0d.failNum", k), 64'(ft),  64'(m_gp[k]));
      chk($sformatf("d%0d.cycles", k),  cc,       64'(m_cyc[k]));
      chk($sformatf("d%0d.fetches", k), fc,       64'(m_fch[k]));
   endtask

   task automatic check_all();
      check_dut(0, done0, pass0, fail0, to0, strb0, halt0, ep0, ftn0, 64'(cc0), 64'(fc0));
      check_dut(1, done1, pass1, fail1, to1, strb1, halt1, ep1, ftn1, 64'(cc1), 64'(fc1));
   endtask

   task automatic cyc();
      @(posedge sysClk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] pc);
      instrValid = v; instrData = d; instrPc = pc;
   endtask

   // Reset lands between edges and is checked before any clock arrives.
   task automatic async_reset();
      #3 sysRes = 1'b0;
      model_reset();
      #1 check_all();
      chk("async.done", 64'(done0 | done1), 64'd0);
      #1 sysRes = 1'b1;
   endtask

   initial begin
      sysRes = 1'b0; clear = 1'b0; gpValue = '0;
      drive(1'b0, '0, '0);
      model_reset();
      #2 check_all();
      #1 sysRes = 1'b1;

      // ECALL in the IDLE cycle right after release is not evaluated.
      drive(1'b1, ECALL, 32'h10);
      cyc();
      chk("idle.ecall_ignored", 64'(pass0), 64'd0);

      for (int i = 0; i < 10; i++) begin
         drive(1'b1, NOP, 32'(4 * i));
         cyc();
      end
      drive(1'b0, ECALL, 32'h80);
      cyc();
      chk("invalid.ecall_ignored", 64'(done0), 64'd0);
      drive(1'b1, ECALL, 32'h88);
      cyc();
      chk("ecall.pass", 64'(pass0), 64'd1);
      chk("ecall.endPc", 64'(ep0), 64'h88);
      chk("ecall.fetches", 64'(fc0), 64'd11);
      chk("ecall.strobe", 64'(strb0), 64'd1);
      drive(1'b1, NOP, 32'h8c);
      cyc();
      chk("ecall.strobe_drop", 64'(strb0), 64'd0);

      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("clear.done", 64'(done0), 64'd0);
      chk("clear.cycles", 64'(cc0), 64'd0);
      chk("clear.strobe", 64'(strb0), 64'd0);
      gpValue = 32'd7;
      drive(1'b1, EBREAK, 32'h1F4);
      cyc();
      chk("ebreak.fail", 64'(fail0), 64'd1);
      chk("ebreak.failNum", 64'(ftn0), 64'd7);
      chk("ebreak.endPc", 64'(ep0), 64'h1F4);
      drive(1'b1, ECALL, 32'h200);
      cyc();
      chk("ebreak.sticky_fail", 64'(fail0), 64'd1);
      chk("ebreak.no_pass", 64'(pass0), 64'd0);

      async_reset();

      // Pure NOP run: short watchdog fires, narrow counters saturate.
      for (int i = 0; i < 25; i++) begin
         drive(1'b1, NOP, 32'(4 * i));
         cyc();
      end
      chk("wd.timeout", 64'(to0), 64'd1);
      chk("wd.endPc", 64'(ep0), 64'd0);
      chk("sat.cycles", 64'(cc1), 64'd15);
      chk("sat.no_timeout", 64'(to1), 64'd0);

      // ECALL on the final watchdog cycle wins over timeout.
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      for (int i = 0; i < 19; i++) begin
         drive(1'b1, NOP, 32'(4 * i));
         cyc();
      end
      drive(1'b1, ECALL, 32'h300);
      cyc();
      chk("edge.pass", 64'(pass0), 64'd1);
      chk("edge.no_timeout", 64'(to0), 64'd0);

      for (int n = 0; n < 600; n++) begin
         int r;
         logic [31:0] d;
         r = int'($urandom_range(0, 99));
         if (r < 3)       d = ECALL;
         else if (r < 6)  d = EBREAK;
         else if (r < 25) d = 32'h3420_2373;
         else if (r < 75) d = NOP;
         else             d = $urandom;
         drive(($urandom_range(0, 3) != 0), d, $urandom);
         gpValue = $urandom;
         clear   = ($urandom_range(0, 39) == 0);
         cyc();
         clear = 1'b0;
         if ($urandom_range(0, 149) == 0) async_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
